// File: rtl/pll_lock_reset_seq.sv
// Purpose: synchronise the PLL lock flag and sequence the downstream synchronous reset.
// Latency: reset_out falls SYNC_STAGES+1+LOCK_STABLE_CYCLES+RESET_HOLD_CYCLES clocks after lock rises, and rises SYNC_STAGES+1 clocks after it drops.
// Backpressure: none; status outputs are free-running and cannot be stalled.
module pll_lock_reset_seq #(
   parameter int SYNC_STAGES        = 2,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int RESET_HOLD_CYCLES  = 16,
   parameter int LOSS_CNT_W         = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  locked,
   output logic                  reset_out,
   output logic                  ready,
   output logic                  lock_lost,
   output logic [LOSS_CNT_W-1:0] loss_count,
   output logic [1:0]            state_out
);

   localparam int MAX_CYCLES = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                               LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [CNT_W-1:0] STABLE_TERM = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_TERM   = CNT_W'(RESET_HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK   = 2'd0,
      WAIT_STABLE = 2'd1,
      HOLD        = 2'd2,
      RUN         = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lock_s;

   state_t                 state;
   state_t                 state_nxt;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_nxt;
   logic                   lost_nxt;
   logic [LOSS_CNT_W-1:0]  loss_nxt;

   // Lock synchroniser: shift the asynchronous flag through SYNC_STAGES flops.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
      end
   end

   assign lock_s = sync_q[SYNC_STAGES-1];

   // Next-state logic; any low lock sample throws away all progress, and a
   // lock drop takes priority over a counter reaching its terminal value.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      lost_nxt  = 1'b0;
      case (state)
         WAIT_LOCK: begin
            cnt_nxt = '0;
            if (lock_s) begin
               state_nxt = WAIT_STABLE;
            end
         end
         WAIT_STABLE: begin
            if (!lock_s) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = '0;
            end else if (cnt == STABLE_TERM) begin
               state_nxt = HOLD;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         HOLD: begin
            if (!lock_s) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = '0;
               lost_nxt  = 1'b1;
            end else if (cnt == HOLD_TERM) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         RUN: begin
            cnt_nxt = '0;
            if (!lock_s) begin
               state_nxt = WAIT_LOCK;
               lost_nxt  = 1'b1;
            end
         end
         default: begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Loss counter saturates at all-ones so a flapping PLL never reads back as healthy.
   always_comb begin
      loss_nxt = loss_count;
      if (lost_nxt && (loss_count != '1)) begin
         loss_nxt = loss_count + 1'b1;
      end
   end

   // State and registered outputs; reset_out tracks the next state so it
   // changes on the same edge the FSM enters or leaves RUN.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= WAIT_LOCK;
         cnt        <= '0;
         reset_out  <= 1'b1;
         lock_lost  <= 1'b0;
         loss_count <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         reset_out  <= (state_nxt != RUN);
         lock_lost  <= lost_nxt;
         loss_count <= loss_nxt;
      end
   end

   assign ready     = ~reset_out;
   assign state_out = state;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Purpose: scoreboard bench for pll_lock_reset_seq with hand-timed expected output changes.
// Latency: expected events are stamped with the absolute clock count at which they must appear.
// Backpressure: none; the monitor samples every falling edge.
module tb_pll_lock_reset_seq;

   localparam int SYNC = 2;
   localparam int LSC  = 8;
   localparam int RHC  = 4;
   localparam int LCW  = 2;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic           locked = 1'b0;
   logic           reset_out;
   logic           ready;
   logic           lock_lost;
   logic [LCW-1:0] loss_count;
   logic [1:0]     state_out;

   typedef struct {
      int         cyc;
      logic [1:0] st;
      logic       ro;
      logic       lost;
      logic [1:0] lc;
   } ev_t;

   ev_t q[$];
   int  cyc    = 0;
   int  checks = 0;
   int  fails  = 0;
   bit  done   = 1'b0;

   pll_lock_reset_seq #(
      .SYNC_STAGES       (SYNC),
      .LOCK_STABLE_CYCLES(LSC),
      .RESET_HOLD_CYCLES (RHC),
      .LOSS_CNT_W        (LCW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .locked    (locked),
      .reset_out (reset_out),
      .ready     (ready),
      .lock_lost (lock_lost),
      .loss_count(loss_count),
      .state_out (state_out)
   );

   always #5 clock = ~clock;

   // Absolute clock counter used to time-stamp expected events.
   always @(posedge clock) cyc <= cyc + 1;

   task automatic push(input int c, input logic [1:0] st, input logic ro,
                       input logic lost, input logic [1:0] lc);
      ev_t e;
      e.cyc = c; e.st = st; e.ro = ro; e.lost = lost; e.lc = lc;
      q.push_back(e);
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clock);
   endtask

   // Clean lock acquisition starting from WAIT_LOCK with locked high from cycle c.
   task automatic push_seq(input int c, input logic [1:0] n);
      push(c + SYNC + 1,             2'd1, 1'b1, 1'b0, n);
      push(c + SYNC + 1 + LSC,       2'd2, 1'b1, 1'b0, n);
      push(c + SYNC + 1 + LSC + RHC, 2'd3, 1'b0, 1'b0, n);
   endtask

   // From RUN: drop locked for 3 clocks, then relock and run the full sequence again.
   task automatic drop3(input logic [1:0] n);
      int d;
      d = cyc;
      locked = 1'b0;
      push(d + SYNC + 1, 2'd0, 1'b1, 1'b1, n);
      push(d + SYNC + 2, 2'd0, 1'b1, 1'b0, n);
      wait_to(d + 3);
      locked = 1'b1;
      push_seq(d + 3, n);
      wait_to(d + 25);
   endtask

   // Master reset pulse asserted mid-cycle; returns the release cycle.
   task automatic pulse_reset(output int rel);
      @(posedge clock);
      #2;
      push(cyc, 2'd0, 1'b1, 1'b0, 2'd0);
      reset = 1'b1;
      wait_to(cyc + 2);
      reset = 1'b0;
      rel = cyc;
   endtask

   // Stimulus.
   initial begin : stim
      int c;
      push(1, 2'd0, 1'b1, 1'b0, 2'd0);
      wait_to(3);
      reset = 1'b0;

      // Lock toggling every 5 clocks never gets past WAIT_STABLE.
      for (int j = 0; j < 3; j++) begin
         c = cyc;
         locked = 1'b1;
         push(c + SYNC + 1, 2'd1, 1'b1, 1'b0, 2'd0);
         push(c + SYNC + 6, 2'd0, 1'b1, 1'b0, 2'd0);
         wait_to(c + 5);
         locked = 1'b0;
         wait_to(c + 10);
      end
      wait_to(cyc + 5);

      // Lock drop arriving exactly as HOLD reaches its terminal count.
      c = cyc;
      locked = 1'b1;
      push(c + SYNC + 1,       2'd1, 1'b1, 1'b0, 2'd0);
      push(c + SYNC + 1 + LSC, 2'd2, 1'b1, 1'b0, 2'd0);
      push(c + 15,             2'd0, 1'b1, 1'b1, 2'd1);
      push(c + 16,             2'd0, 1'b1, 1'b0, 2'd1);
      wait_to(c + 12);
      locked = 1'b0;
      wait_to(c + 22);

      // Locked held high across reset release: 15-clock sequence.
      locked = 1'b1;
      pulse_reset(c);
      push_seq(c, 2'd0);
      wait_to(c + 20);

      // Lock loss from RUN and recovery.
      drop3(2'd1);

      // Master reset mid-RUN, then mid-HOLD.
      pulse_reset(c);
      push(c + SYNC + 1,       2'd1, 1'b1, 1'b0, 2'd0);
      push(c + SYNC + 1 + LSC, 2'd2, 1'b1, 1'b0, 2'd0);
      wait_to(c + 12);
      pulse_reset(c);
      push_seq(c, 2'd0);
      wait_to(c + 20);

      // Five losses with a 2-bit counter: 1,2,3,3,3.
      drop3(2'd1);
      drop3(2'd2);
      drop3(2'd3);
      drop3(2'd3);
      drop3(2'd3);

      wait_to(cyc + 5);
      done = 1'b1;
   end

   // Monitor: pops an expected event on every output change, checks
   // asynchronous reset response, and reports the summary.
   initial begin : monitor
      logic [6:0] cur;
      logic [6:0] prev;
      logic [6:0] exp;
      ev_t        e;
      prev = 'x;
      forever begin
         @(negedge clock or posedge reset);
         if (clock) begin
            #1;
            cur = {state_out, reset_out, ready, lock_lost, loss_count};
            checks++;
            if (cur !== 7'b00_1_0_0_00) begin
               fails++;
               $display("FAIL async_reset t=%0t got st=%0d ro=%b rdy=%b lost=%b cnt=%0d exp st=0 ro=1 rdy=0 lost=0 cnt=0",
                        $time, state_out, reset_out, ready, lock_lost, loss_count);
            end
         end else if (done) begin
            checks++;
            if (q.size() != 0) begin
               fails++;
               $display("FAIL leftover_events got=%0d exp=0 next_cyc=%0d", q.size(), q[0].cyc);
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
            $finish;
         end else begin
            cur = {state_out, reset_out, ready, lock_lost, loss_count};
            if (cur !== prev) begin
               checks++;
               if (q.size() == 0) begin
                  fails++;
                  $display("FAIL unexpected_change cyc=%0d got st=%0d ro=%b rdy=%b lost=%b cnt=%0d exp no change",
                           cyc, state_out, reset_out, ready, lock_lost, loss_count);
               end else begin
                  e   = q.pop_front();
                  exp = {e.st, e.ro, ~e.ro, e.lost, e.lc};
                  if (cur !== exp || cyc != e.cyc) begin
                     fails++;
                     $display("FAIL event cyc=%0d got st=%0d ro=%b rdy=%b lost=%b cnt=%0d exp cyc=%0d st=%0d ro=%b rdy=%b lost=%b cnt=%0d",
                              cyc, state_out, reset_out, ready, lock_lost, loss_count,
                              e.cyc, e.st, e.ro, ~e.ro, e.lost, e.lc);
                  end
               end
               prev = cur;
            end else if (q.size() > 0 && q[0].cyc < cyc) begin
               checks++;
               fails++;
               e = q.pop_front();
               $display("FAIL missed_event cyc=%0d got st=%0d ro=%b lost=%b cnt=%0d exp cyc=%0d st=%0d ro=%b lost=%b cnt=%0d",
                        cyc, state_out, reset_out, lock_lost, loss_count,
                        e.cyc, e.st, e.ro, e.lost, e.lc);
            end
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin : watchdog
      #100000;
      $display("FAIL timeout got=no_summary exp=summary_before_100000");
      $fatal(1, "timeout");
   end

endmodule
